// File: rtl/apb_pkg.sv
// Shared APB definitions for the bridge and its completers.
// Holds bus widths, FSM states, response codes and an index-width helper.
package apb_pkg;

   localparam int unsigned APB_DATA_W = 32;
   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_STRB_W = 4;

   // Same encoding as the bridge's bresp/rresp
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      IDLE,
      ACCESS
   } apb_state_e;

   function automatic int unsigned idx_w(input int unsigned num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational range/alignment/protection check and register index generation.
// Also reused by the bridge's slave-select logic.
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REGS  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned PRIV_ONLY = 0
) (
   input  logic [APB_ADDR_W-1:0]       paddr,
   input  logic [2:0]                  pprot,
   output logic                        addr_err,
   output logic [idx_w(NUM_REGS)-1:0]  index
);

   localparam int unsigned IDX_W  = idx_w(NUM_REGS);
   localparam int unsigned SPAN_W = $clog2(NUM_REGS) + 2;

   logic [APB_ADDR_W:0] diff;
   logic                in_range;
   logic                aligned;
   logic                priv_ok;
   logic                unused_prot;

   // One extra bit so the borrow flags addresses below the base
   assign diff        = {1'b0, paddr} - {1'b0, BASE_ADDR};
   assign in_range    = !diff[APB_ADDR_W] && (diff[APB_ADDR_W-1:SPAN_W] == '0);
   assign aligned     = (diff[1:0] == 2'b00);
   assign priv_ok     = (PRIV_ONLY == 0) || pprot[0];
   assign addr_err    = !(in_range && aligned && priv_ok);
   assign index       = diff[IDX_W+1:2];
   assign unused_prot = ^pprot[2:1];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of byte-strobed 32-bit registers, programmable
// wait states, and pslverr on out-of-range, unaligned or unprivileged access.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned PRIV_ONLY   = 0
) (
   input  logic                        s_axi_clk,
   input  logic                        s_axi_aresetn,
   input  logic [31:0]                 paddr,
   input  logic [2:0]                  pprot,
   input  logic                        psel,
   input  logic                        penable,
   input  logic                        pwrite,
   input  logic [31:0]                 pwdata,
   input  logic [3:0]                  pstrb,
   output logic                        pready,
   output logic [31:0]                 prdata,
   output logic                        pslverr,
   output logic                        wr_pulse,
   output logic [idx_w(NUM_REGS)-1:0]  wr_index
);

   localparam int unsigned IDX_W = idx_w(NUM_REGS);

   apb_state_e             state_q, state_d;
   logic [3:0]             wait_q, wait_d;
   logic                   err_q, err_d;
   logic                   dec_err;
   logic [IDX_W-1:0]       dec_idx;
   logic                   commit;
   logic [APB_DATA_W-1:0]  regs [NUM_REGS];

   apb_addr_decode #(
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (BASE_ADDR),
      .PRIV_ONLY (PRIV_ONLY)
   ) u_decode (
      .paddr    (paddr),
      .pprot    (pprot),
      .addr_err (dec_err),
      .index    (dec_idx)
   );

   always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q <= IDLE;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   // Error is latched at setup; index and data are taken live at completion
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      pready  = 1'b0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACCESS;
               wait_d  = 4'(WAIT_STATES);
               err_d   = dec_err;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               if (wait_q == '0) begin
                  pready  = 1'b1;
                  state_d = IDLE;
               end else begin
                  wait_d = wait_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pslverr = pready && err_q;
      commit  = pready && !err_q && pwrite;
      prdata  = '0;
      if (pready && !err_q && !pwrite) begin
         prdata = regs[dec_idx];
      end
   end

   always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (commit) begin
         for (int unsigned b = 0; b < APB_STRB_W; b++) begin
            if (pstrb[b]) begin
               regs[dec_idx][8*b +: 8] <= pwdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wr_pulse <= 1'b0;
         wr_index <= '0;
      end else begin
         wr_pulse <= commit;
         if (commit) begin
            wr_index <= dec_idx;
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: two register-file instances (2 wait states + privileged-only,
// and zero wait states at base 0x100) checked against a behavioural memory model.
module tb_apb_slave_regfile;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic        psel_a, psel_b;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;

   logic        pready_a, pslverr_a, wr_pulse_a;
   logic [31:0] prdata_a;
   logic [3:0]  wr_index_a;
   logic        pready_b, pslverr_b, wr_pulse_b;
   logic [31:0] prdata_b;
   logic [3:0]  wr_index_b;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_a [16];
   logic [31:0] mem_b [16];
   logic [3:0]  last_a, last_b;

   always #5 clk = ~clk;

   apb_slave_regfile #(
      .NUM_REGS    (16),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (2),
      .PRIV_ONLY   (1)
   ) dut_a (
      .s_axi_clk     (clk),
      .s_axi_aresetn (aresetn),
      .paddr         (paddr),
      .pprot         (pprot),
      .psel          (psel_a),
      .penable       (penable),
      .pwrite        (pwrite),
      .pwdata        (pwdata),
      .pstrb         (pstrb),
      .pready        (pready_a),
      .prdata        (prdata_a),
      .pslverr       (pslverr_a),
      .wr_pulse      (wr_pulse_a),
      .wr_index      (wr_index_a)
   );

   apb_slave_regfile #(
      .NUM_REGS    (16),
      .BASE_ADDR   (32'h0000_0100),
      .WAIT_STATES (0),
      .PRIV_ONLY   (0)
   ) dut_b (
      .s_axi_clk     (clk),
      .s_axi_aresetn (aresetn),
      .paddr         (paddr),
      .pprot         (pprot),
      .psel          (psel_b),
      .penable       (penable),
      .pwrite        (pwrite),
      .pwdata        (pwdata),
      .pstrb         (pstrb),
      .pready        (pready_b),
      .prdata        (prdata_b),
      .pslverr       (pslverr_b),
      .wr_pulse      (wr_pulse_b),
      .wr_index      (wr_index_b)
   );

   // ---------------- reference model ----------------
   function automatic bit model_err(input bit b, input logic [31:0] a, input logic [2:0] p);
      longint base = b ? 64'd256 : 64'd0;
      longint ad   = longint'(a);
      if (ad < base || ad >= base + 64) return 1'b1;
      if (a % 4 != 0) return 1'b1;
      if (!b && !p[0]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int model_idx(input bit b, input logic [31:0] a);
      return int'((a - (b ? 32'd256 : 32'd0)) / 4);
   endfunction

   task automatic model_xfer(input bit b, input logic [31:0] a, input bit w,
                             input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                             output logic [31:0] erd, output logic eerr,
                             output logic epulse, output logic [3:0] eidx);
      logic [31:0] mask;
      int k;
      eerr   = model_err(b, a, p);
      erd    = '0;
      epulse = 1'b0;
      mask   = '0;
      for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hFF << (8 * i));
      if (!eerr) begin
         k = model_idx(b, a);
         if (w) begin
            epulse = 1'b1;
            if (b) begin
               mem_b[k] = (mem_b[k] & ~mask) | (d & mask);
               last_b   = 4'(k);
            end else begin
               mem_a[k] = (mem_a[k] & ~mask) | (d & mask);
               last_a   = 4'(k);
            end
         end else begin
            erd = b ? mem_b[k] : mem_a[k];
         end
      end
      eidx = b ? last_b : last_a;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      last_a = '0;
      last_b = '0;
   endtask

   // ---------------- bus driver ----------------
   // Called #1 after a rising edge; returns #1 after the edge following completion.
   task automatic xfer(input bit b, input logic [31:0] a, input bit w,
                       input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic pulse, output logic [3:0] widx);
      paddr   = a;
      pwrite  = w;
      pwdata  = d;
      pstrb   = s;
      pprot   = p;
      penable = 1'b0;
      psel_a  = !b;
      psel_b  = b;
      @(posedge clk); #1;
      penable = 1'b1;
      lat = 99;
      rd  = '0;
      er  = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (b ? pready_b : pready_a) begin
            lat = i;
            rd  = b ? prdata_b : prdata_a;
            er  = b ? pslverr_b : pslverr_a;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      pulse = b ? wr_pulse_b : wr_pulse_a;
      widx  = b ? wr_index_b : wr_index_a;
   endtask

   task automatic bus_idle();
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      aresetn = 1'b0;
      psel_a = 0; psel_b = 0; penable = 0; pwrite = 0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      model_clear();
      #12;
      total++;
      if ({pready_a, pslverr_a, wr_pulse_a, pready_b, pslverr_b, wr_pulse_b} !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b want=000000",
                  {pready_a, pslverr_a, wr_pulse_a, pready_b, pslverr_b, wr_pulse_b});
      end
      total++;
      if (prdata_a !== 32'h0 || prdata_b !== 32'h0 || wr_index_a !== 4'h0 || wr_index_b !== 4'h0) begin
         bad++;
         $display("FAIL reset_data got=%h/%h/%h/%h want=0", prdata_a, prdata_b, wr_index_a, wr_index_b);
      end
      @(negedge clk);
      aresetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic er, pu; logic [3:0] wi; int lat;
      xfer(0, 32'h8, 1, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, lat, pu, wi);
      void'(model_err(0, 32'h8, 3'b001));
      mem_a[2] = 32'hDEADBEEF; last_a = 4'd2;
      total++;
      if (lat !== 3 || er !== 1'b0) begin
         bad++; $display("FAIL wr_latency got lat=%0d err=%b want lat=3 err=0", lat, er);
      end
      total++;
      if (pu !== 1'b1 || wi !== 4'd2) begin
         bad++; $display("FAIL wr_pulse got pulse=%b idx=%0d want pulse=1 idx=2", pu, wi);
      end
      xfer(0, 32'h8, 0, 32'h0, 4'h0, 3'b001, rd, er, lat, pu, wi);
      total++;
      if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
         bad++; $display("FAIL rd_back got lat=%0d err=%b data=%h want 3/0/deadbeef", lat, er, rd);
      end
      total++;
      if (pu !== 1'b0) begin
         bad++; $display("FAIL rd_nopulse got=%b want=0", pu);
      end
      bus_idle();
   endtask

   task automatic test_strobes();
      logic [31:0] rd, erd; logic er, pu, eer, epu; logic [3:0] wi, ewi; int lat;
      xfer(0, 32'h4, 1, 32'h11223344, 4'hF, 3'b001, rd, er, lat, pu, wi);
      model_xfer(0, 32'h4, 1, 32'h11223344, 4'hF, 3'b001, erd, eer, epu, ewi);
      xfer(0, 32'h4, 1, 32'hAABBCCDD, 4'b0101, 3'b011, rd, er, lat, pu, wi);
      model_xfer(0, 32'h4, 1, 32'hAABBCCDD, 4'b0101, 3'b011, erd, eer, epu, ewi);
      xfer(0, 32'h4, 0, 32'h0, 4'hF, 3'b001, rd, er, lat, pu, wi);
      total++;
      if (rd !== 32'h11BB33DD || er !== 1'b0) begin
         bad++; $display("FAIL strobe_merge got=%h err=%b want=11bb33dd err=0", rd, er);
      end
      xfer(0, 32'h4, 1, 32'hFFFFFFFF, 4'h0, 3'b001, rd, er, lat, pu, wi);
      model_xfer(0, 32'h4, 1, 32'hFFFFFFFF, 4'h0, 3'b001, erd, eer, epu, ewi);
      total++;
      if (er !== 1'b0 || pu !== 1'b1 || wi !== 4'd1) begin
         bad++; $display("FAIL strobe_zero got err=%b pulse=%b idx=%0d want 0/1/1", er, pu, wi);
      end
      xfer(0, 32'h4, 0, 32'h0, 4'h0, 3'b001, rd, er, lat, pu, wi);
      total++;
      if (rd !== 32'h11BB33DD) begin
         bad++; $display("FAIL strobe_zero_rd got=%h want=11bb33dd", rd);
      end
      bus_idle();
   endtask

   task automatic test_errors();
      logic [31:0] rd, erd; logic er, pu, eer, epu; logic [3:0] wi, ewi; int lat;
      logic [31:0] ea [4] = '{32'h40, 32'h6, 32'h0, 32'hFC};
      bit          ew [4] = '{0, 1, 1, 0};
      bit          eb [4] = '{0, 0, 0, 1};
      logic [2:0]  ep [4] = '{3'b001, 3'b001, 3'b000, 3'b001};
      for (int i = 0; i < 4; i++) begin
         xfer(eb[i], ea[i], ew[i], 32'hCAFEF00D, 4'hF, ep[i], rd, er, lat, pu, wi);
         model_xfer(eb[i], ea[i], ew[i], 32'hCAFEF00D, 4'hF, ep[i], erd, eer, epu, ewi);
         total++;
         if (er !== 1'b1 || rd !== 32'h0 || lat !== (eb[i] ? 1 : 3)) begin
            bad++; $display("FAIL err_resp[%0d] got err=%b data=%h lat=%0d want 1/0/%0d",
                            i, er, rd, lat, eb[i] ? 1 : 3);
         end
         total++;
         if (pu !== 1'b0 || wi !== ewi) begin
            bad++; $display("FAIL err_nopulse[%0d] got pulse=%b idx=%0d want 0/%0d", i, pu, wi, ewi);
         end
      end
      xfer(0, 32'h0, 0, 32'h0, 4'hF, 3'b001, rd, er, lat, pu, wi);
      total++;
      if (rd !== mem_a[0] || er !== 1'b0) begin
         bad++; $display("FAIL err_unchanged got=%h want=%h", rd, mem_a[0]);
      end
      bus_idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, erd; logic er, pu, eer, epu; logic [3:0] wi, ewi; int lat;
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         xfer(1, 32'h100 + 32'(4 * i), 1, d, 4'hF, 3'b000, rd, er, lat, pu, wi);
         model_xfer(1, 32'h100 + 32'(4 * i), 1, d, 4'hF, 3'b000, erd, eer, epu, ewi);
         total++;
         if (lat !== 1 || er !== 1'b0 || pu !== 1'b1 || wi !== 4'(i)) begin
            bad++; $display("FAIL b2b_wr[%0d] got lat=%0d err=%b pulse=%b idx=%0d want 1/0/1/%0d",
                            i, lat, er, pu, wi, i);
         end
      end
      for (int i = 0; i < 4; i++) begin
         xfer(1, 32'h100 + 32'(4 * i), 0, 32'h0, 4'h0, 3'b000, rd, er, lat, pu, wi);
         total++;
         if (rd !== mem_b[i] || lat !== 1) begin
            bad++; $display("FAIL b2b_rd[%0d] got=%h lat=%0d want=%h lat=1", i, rd, lat, mem_b[i]);
         end
      end
      bus_idle();
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er, pu; logic [3:0] wi; int lat;
      paddr = 32'h0; pwrite = 1; pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b001;
      psel_a = 1; psel_b = 0; penable = 0;
      @(posedge clk); #1;
      penable = 1;
      @(negedge clk);
      aresetn = 1'b0;
      #1;
      total++;
      if (pready_a !== 1'b0 || pslverr_a !== 1'b0) begin
         bad++; $display("FAIL rst_mid_resp got rdy=%b err=%b want 0/0", pready_a, pslverr_a);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (pready_a !== 1'b0 || pslverr_a !== 1'b0 || wr_pulse_a !== 1'b0) begin
         bad++; $display("FAIL rst_mid_hold got rdy=%b err=%b pulse=%b want 0/0/0",
                         pready_a, pslverr_a, wr_pulse_a);
      end
      psel_a = 0; penable = 0;
      aresetn = 1'b1;
      model_clear();
      @(posedge clk); #1;
      xfer(0, 32'h0, 0, 32'h0, 4'h0, 3'b001, rd, er, lat, pu, wi);
      total++;
      if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
         bad++; $display("FAIL rst_mid_rd got=%h err=%b lat=%0d want 0/0/3", rd, er, lat);
      end
      bus_idle();
   endtask

   task automatic test_protocol_abuse();
      logic [31:0] rd, erd; logic er, pu, eer, epu; logic [3:0] wi, ewi; int lat;
      xfer(0, 32'h8, 1, 32'h01020304, 4'hF, 3'b001, rd, er, lat, pu, wi);
      model_xfer(0, 32'h8, 1, 32'h01020304, 4'hF, 3'b001, erd, eer, epu, ewi);
      // setup, then psel dropped where the access phase should start
      paddr = 32'h8; pwrite = 1; pwdata = 32'hFFFF0000; pstrb = 4'hF; pprot = 3'b001;
      psel_a = 1; penable = 0;
      @(posedge clk); #1;
      psel_a = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (pready_a !== 1'b0 || wr_pulse_a !== 1'b0) begin
            bad++; $display("FAIL abuse_drop[%0d] got rdy=%b pulse=%b want 0/0", i, pready_a, wr_pulse_a);
         end
         @(posedge clk); #1;
      end
      xfer(0, 32'h8, 0, 32'h0, 4'h0, 3'b001, rd, er, lat, pu, wi);
      total++;
      if (rd !== 32'h01020304 || er !== 1'b0 || lat !== 3) begin
         bad++; $display("FAIL abuse_rd got=%h err=%b lat=%0d want 01020304/0/3", rd, er, lat);
      end
      // penable held low inside ACCESS must freeze the wait count
      paddr = 32'h8; pwrite = 0; psel_a = 1; penable = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (pready_a !== 1'b0) begin
            bad++; $display("FAIL hold_noready[%0d] got=%b want=0", i, pready_a);
         end
         @(posedge clk); #1;
      end
      penable = 1;
      lat = 99;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (pready_a) begin
            lat = i;
            rd  = prdata_a;
            break;
         end
         @(posedge clk); #1;
      end
      total++;
      if (lat !== 3 || rd !== 32'h01020304) begin
         bad++; $display("FAIL hold_latency got lat=%0d data=%h want 3/01020304", lat, rd);
      end
      @(posedge clk); #1;
      bus_idle();
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, d; logic er, pu, eer, epu; logic [3:0] wi, ewi, s; int lat;
      bit b, w; logic [2:0] p;
      for (int n = 0; n < 80; n++) begin
         b = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         a = (b ? 32'h100 : 32'h0) - 32'd8 + 32'($urandom_range(0, 80));
         if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
         d = $urandom;
         s = 4'($urandom);
         p = 3'($urandom);
         if ($urandom_range(0, 3) != 0) p[0] = 1'b1;
         xfer(b, a, w, d, s, p, rd, er, lat, pu, wi);
         model_xfer(b, a, w, d, s, p, erd, eer, epu, ewi);
         total++;
         if (er !== eer || rd !== erd || lat !== (b ? 1 : 3)) begin
            bad++; $display("FAIL rnd_resp[%0d] b=%0d a=%h w=%0d got err=%b data=%h lat=%0d want %b/%h/%0d",
                            n, b, a, w, er, rd, lat, eer, erd, b ? 1 : 3);
         end
         total++;
         if (pu !== epu || wi !== ewi) begin
            bad++; $display("FAIL rnd_pulse[%0d] got pulse=%b idx=%0d want %b/%0d", n, pu, wi, epu, ewi);
         end
         if ($urandom_range(0, 2) == 0) bus_idle();
      end
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_strobes();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_protocol_abuse();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB3/APB4 completer that sits directly downstream of the AXI4-Lite-to-APB bridge, on one bit of its per-slave select vector.
- Provides a bank of 32-bit read/write registers with byte-strobe writes.
- Inserts a programmable number of wait states by holding pready low.
- Flags bad accesses with pslverr: out-of-range address, unaligned address, or protection violation.
- Serves as the standard end-point for bridge integration and as the template for peripheral slaves.

Parameters:
NUM_REGS, 16, number of 32-bit registers (power of two, 1..256)
BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to 4*NUM_REGS
WAIT_STATES, 2, access-phase cycles with pready low before completion (0..15)
PRIV_ONLY, 0, 1 = reject transfers with pprot[0]==0 using pslverr

Ports:
s_axi_clk  in  1  clock, shared with the bridge
s_axi_aresetn  in  1  asynchronous active-low reset
paddr  in  32  byte address
pprot  in  3  protection attributes
psel  in  1  select (one bit of the bridge's psel vector)
penable  in  1  access phase
pwrite  in  1  1 = write
pwdata  in  32  write data
pstrb  in  4  byte lane strobes
pready  out  1  transfer complete
prdata  out  32  read data
pslverr  out  1  error response, valid only with pready
wr_pulse  out  1  one-cycle pulse the cycle after any successful write commits
wr_index  out  $clog2(NUM_REGS) (min 1)  register index of the last successful write

Behaviour:
- Reset: clock s_axi_clk; reset s_axi_aresetn, asynchronous, active-low. Reset clears all registers, wr_index, state and wait counter to 0. pready, pslverr, wr_pulse and prdata are 0 during reset.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on psel && !penable (setup phase). Load wait_cnt=WAIT_STATES. Latch addr_err, computed from paddr/pprot.
  - In ACCESS, each cycle with psel && penable and wait_cnt!=0: decrement wait_cnt; pready=0.
  - In ACCESS, when psel && penable && wait_cnt==0: pready=1 (combinational from state/counter). Next state is IDLE.
  - Access phase therefore lasts exactly WAIT_STATES+1 cycles. Setup-to-pready latency is WAIT_STATES+1 cycles.
- addr_err conditions (any one): paddr < BASE_ADDR; paddr >= BASE_ADDR+4*NUM_REGS; paddr[1:0] != 0; PRIV_ONLY && !pprot[0].
- Register index = (paddr-BASE_ADDR)>>2, truncated to the index width.
- Completion cycle with addr_err:
  - pslverr=1 and prdata=0.
  - No register is modified and wr_pulse stays low.
- Completion cycle, write, no error:
  - At the clock edge, each register byte b is updated with pwdata[8b+7:8b] where pstrb[b]==1.
  - pstrb==0 is a legal no-op write: OKAY response, wr_pulse still fires.
  - wr_index is updated and wr_pulse=1 in the following cycle.
- Completion cycle, read, no error: prdata=reg[index], combinational. pstrb is ignored.
- prdata is 0 in every cycle other than a successful read completion.
- pslverr is 0 whenever pready is 0.
- Back-to-back transfers: a new setup phase is accepted in the cycle immediately after completion, since the FSM is already in IDLE.
- psel deasserted while in ACCESS (protocol violation): return to IDLE with no commit and no response.
- penable low while in ACCESS: hold the counter and keep pready low.
- Reset asserted mid-transfer: immediate abort. No partial write; all registers read 0 after release.
- The latched paddr/pwrite/pwdata/pstrb values are not used. Inputs are sampled live in the completion cycle, per the APB rule that they are stable for the whole transfer.

Decomposition:
- Shared package apb_pkg holds:
  - APB_DATA_W=32, APB_ADDR_W=32, APB_STRB_W=4.
  - FSM state enum {IDLE, ACCESS}.
  - Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, shared with the bridge's bresp/rresp encoding.
- One sub-module is natural: apb_addr_decode. It is purely combinational: in-range, aligned and protection check plus index generation, parameterised by BASE_ADDR/NUM_REGS/PRIV_ONLY. The bridge's slave-select logic reuses it.
- Register array, FSM and wait counter stay in the top module.

Test Plan:
- Write then read, WAIT_STATES=2, BASE_ADDR=0: write 32'hDEADBEEF to 0x8 with pstrb=4'hF, then read 0x8 -> pready high on the 3rd access cycle, pslverr=0, prdata=32'hDEADBEEF; wr_pulse=1 with wr_index=2 one cycle after write completion.
- Byte strobes: reg1=32'h11223344, then write 32'hAABBCCDD to 0x4 with pstrb=4'b0101 -> readback 32'h11BB33DD. A pstrb=0 write leaves the value unchanged with OKAY.
- Errors, NUM_REGS=16: read 0x40 (out of range), write 0x6 (unaligned), and with PRIV_ONLY=1 a write with pprot=3'b000 -> each gives pready with pslverr=1 and prdata=0, no register change, no wr_pulse.
- Zero wait and back-to-back, WAIT_STATES=0: four consecutive writes 0x0..0xC with no idle cycles -> pready in every access phase; all four values read back correctly.
- Reset mid-transfer: assert s_axi_aresetn=0 during the wait cycles of a write to 0x0 -> pready and pslverr stay 0; a read of 0x0 after release returns 32'h0.
- Protocol abuse: drop psel in the 1st access cycle -> FSM returns to IDLE with no commit; a following legal read completes normally.
